// File: rtl/fir_pkg.sv
// Shared constants and encodings for the 3-tap FIR MAC sequencer.
// Default coefficients are 1, 2 and 3.
package fir_pkg;
  localparam int DATA_W  = 8;
  localparam int COEFF_W = 8;
  localparam int TAPS    = 3;
  localparam int TAP_W   = 2;
  localparam int ACC_W   = DATA_W + COEFF_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [COEFF_W-1:0] coef_default(
    input int i
  );
    return COEFF_W'(i + 1);
  endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// Registered multiply-accumulate with synchronous clear.
// sum is the value acc takes on the next enabled edge.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr,
  input  logic               en,
  input  logic [DATA_W-1:0]  a,
  input  logic [COEFF_W-1:0] b,
  output logic [ACC_W-1:0]   acc,
  output logic [ACC_W-1:0]   sum
);
  localparam int PW = DATA_W + COEFF_W;

  logic [PW-1:0] prod;

  assign prod = {{COEFF_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign sum  = acc + {{(ACC_W-PW){1'b0}}, prod};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// 3-tap FIR sequencer: one MAC per cycle over a shared multiplier,
// sample and result on valid/ready, runtime coefficient writes.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               coef_we,
  input  logic [TAP_W-1:0]   coef_addr,
  input  logic [COEFF_W-1:0] coef_data,
  output logic               coef_ack,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy
);
  state_t state, state_nxt;

  logic [TAP_W-1:0]   tap;
  logic [DATA_W-1:0]  dl [TAPS];
  logic [COEFF_W-1:0] cf [TAPS];
  logic               accept;
  logic               retire;
  logic               mac_en;
  logic               last;
  logic [ACC_W-1:0]   mac_acc;
  logic [ACC_W-1:0]   mac_sum;

  assign last = (tap == TAP_W'(TAPS - 1));
  assign coef_ack = coef_we && (state != S_MAC)
                 && (coef_addr < TAP_W'(TAPS));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mac_en    = 1'b0;
    accept    = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = S_MAC;
      end
      S_MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready;
        retire   = out_ready;
        accept   = in_valid && out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? S_MAC : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dl[i] <= '0;
        cf[i] <= coef_default(i);
      end
    end else begin
      if (accept) begin
        dl[0] <= in_data;
        for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
        tap <= '0;
      end else if (mac_en) begin
        tap <= tap + 1'b1;
      end
      for (int i = 0; i < TAPS; i++) begin
        if (coef_ack && coef_addr == TAP_W'(i)) begin
          cf[i] <= coef_data;
        end
      end
      // final tap folds straight into the result register
      if (mac_en && last) begin
        out_data  <= mac_sum;
        out_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

  fir_mac_unit u_mac (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .en  (mac_en),
    .a   (dl[tap]),
    .b   (cf[tap]),
    .acc (mac_acc),
    .sum (mac_sum)
  );
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: transaction model plus
// directed vectors with literal expected results.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               coef_we;
  logic [TAP_W-1:0]   coef_addr;
  logic [COEFF_W-1:0] coef_data;
  logic               coef_ack;
  logic               out_valid;
  logic [ACC_W-1:0]   out_data;
  logic               out_ready;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ACC_W-1:0] res_q [$];

  fir_mac_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_ack  (coef_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Model: a sample accepted at an edge yields its full
  // FIR sum as a result that appears 3 edges later.
  int mx [3] = '{0, 0, 0};
  int mc [3] = '{1, 2, 3};
  int mcnt   = 0;
  bit mvalid = 1'b0;
  int my     = 0;
  int mpend  = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mx     = '{0, 0, 0};
      mc     = '{1, 2, 3};
      mcnt   = 0;
      mvalid = 1'b0;
      my     = 0;
      mpend  = 0;
    end else begin
      bit acc_in;
      acc_in = in_valid && mcnt == 0
            && (!mvalid || out_ready);
      if (coef_we && mcnt == 0 && coef_addr < 3)
        mc[coef_addr] = int'(coef_data);
      if (mvalid && out_ready) mvalid = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mvalid = 1'b1;
          my     = mpend;
        end
      end
      if (acc_in) begin
        mx[2] = mx[1];
        mx[1] = mx[0];
        mx[0] = int'(in_data);
        mpend = mc[0]*mx[0] + mc[1]*mx[1] + mc[2]*mx[2];
        mcnt  = 3;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_data", 32'(out_data), 0);
    end else begin
      chk("in_ready", 32'(in_ready),
          32'(mcnt == 0 && (!mvalid || out_ready)));
      chk("busy", 32'(busy), 32'(mcnt > 0));
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      chk("coef_ack", 32'(coef_ack),
          32'(coef_we && mcnt == 0 && coef_addr < 3));
      if (mvalid) chk("out_data", 32'(out_data), my);
      if (out_valid && out_ready) res_q.push_back(out_data);
    end
  end

  task automatic send(input logic [DATA_W-1:0] x);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    chk("send_timeout", 32'(ok), 1);
  endtask

  task automatic wcoef(
    input logic [TAP_W-1:0]   a,
    input logic [COEFF_W-1:0] d,
    input logic               exp_ack
  );
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge CLK);
    chk("wcoef_ack", 32'(coef_ack), 32'(exp_ack));
    @(posedge CLK);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge CLK);
    #1;
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [ACC_W-1:0] held;
    int lat;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", 32'(in_ready), 1);
    @(posedge CLK);
    #1;

    // default coefficients, streaming
    res_q.delete();
    send(1);
    send(2);
    send(3);
    send(4);
    drain();
    chk("t1_count", res_q.size(), 4);
    if (res_q.size() == 4) begin
      chk("t1_y0", 32'(res_q[0]), 1);
      chk("t1_y1", 32'(res_q[1]), 4);
      chk("t1_y2", 32'(res_q[2]), 10);
      chk("t1_y3", 32'(res_q[3]), 16);
    end

    // full-scale coefficients and samples
    wcoef(0, 255, 1'b1);
    wcoef(1, 255, 1'b1);
    wcoef(2, 255, 1'b1);
    send(255);
    send(255);
    send(255);
    drain();
    chk("t2_max", 32'(res_q[$]), 195075);

    // back-pressure, then retire + accept together
    out_ready = 1'b0;
    send(10);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) break;
    end
    chk("t3_valid", 32'(out_valid), 1);
    held = out_data;
    chk("t3_value", 32'(held), 132600);
    repeat (10) begin
      @(negedge CLK);
      chk("t3_stable", 32'(out_data), 32'(held));
      chk("t3_in_ready", 32'(in_ready), 0);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    send(20);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk("t3_latency", lat, 3);
    drain();
    chk("t3_held_out", 32'(res_q[$-1]), 132600);
    chk("t3_next", 32'(res_q[$]), 72675);

    // coefficient write during MAC is dropped
    rst_pulse();
    send(1);
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'd5;
    @(negedge CLK);
    chk("t4_mac_ack", 32'(coef_ack), 0);
    @(posedge CLK);
    #1;
    coef_we = 1'b0;
    drain();
    chk("t4_unchanged", 32'(res_q[$]), 1);
    rst_pulse();
    wcoef(0, 5, 1'b1);
    send(2);
    drain();
    chk("t4_new_c0", 32'(res_q[$]), 10);

    // out-of-range address is ignored
    rst_pulse();
    wcoef(3, 99, 1'b0);
    send(5);
    send(6);
    drain();
    chk("t5_y0", 32'(res_q[$-1]), 5);
    chk("t5_y1", 32'(res_q[$]), 16);

    // reset in the middle of a MAC sequence
    rst_pulse();
    send(3);
    @(posedge CLK);
    #1;
    chk("t6_busy_pre", 32'(busy), 1);
    RST = 1'b1;
    #1;
    chk("t6_valid_rst", 32'(out_valid), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    send(7);
    drain();
    chk("t6_after", 32'(res_q[$]), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
